smvm_result_collector: RTL and testbench

Sits directly downstream of the SMVM core. It captures the core's serial 14-bit output stream, where each 28-bit row result arrives as two consecutive words, high half first. It reassembles each 28-bit signed row result, tags it with its row index, and buffers it in a small FIFO. Results are presented on a valid/ready interface so a host or bus can drain them at its own rate; the SMVM core itself cannot be back-pressured.

---
 rtl/smvm_pkg.sv | 23 ++
 rtl/smvm_res_fifo.sv | 71 +++++++
 rtl/smvm_result_collector.sv | 140 ++++++++++++++
 tb/tb_smvm_result_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared widths, state encoding and FIFO entry layout for the SMVM result collector.
package smvm_pkg;

  localparam int HALF_W = 14;
  localparam int ACC_W  = 2 * HALF_W;
  localparam int ROW_W  = 8;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [ROW_W-1:0] row;
    logic             last;
  } res_entry_t;

  localparam int ENTRY_W = ACC_W + ROW_W + 1;

endpackage

// File: rtl/smvm_res_fifo.sv
// Synchronous FIFO with wrap-around pointers and a separately tracked occupancy count.
module smvm_res_fifo
  import smvm_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/smvm_result_collector.sv
// Reassembles hi/lo SMVM output words into tagged 28-bit row results and
// buffers them for a valid/ready consumer; the SMVM side is never stalled.
module smvm_result_collector
  import smvm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              in_valid,
  input  logic [HALF_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              extra_err
);

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [HALF_W-1:0]   hi_q, hi_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]    num_rows_q, num_rows_d;
  logic                overflow_q, overflow_d;
  logic                extra_err_q, extra_err_d;
  logic                done_q, done_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  res_entry_t          push_entry, head;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                is_last, push_ok;

  assign fifo_pop  = res_valid && res_ready;
  assign push_ok   = !fifo_full || fifo_pop;
  assign is_last   = (row_cnt_q == (num_rows_q - ROW_W'(1)));

  assign push_entry.data = {hi_q, in_data};
  assign push_entry.row  = row_cnt_q;
  assign push_entry.last = is_last;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    row_cnt_d   = row_cnt_q;
    num_rows_d  = num_rows_q;
    overflow_d  = overflow_q;
    extra_err_d = extra_err_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_rows_d  = num_rows;
          row_cnt_d   = '0;
          phase_d     = 1'b0;
          overflow_d  = 1'b0;
          extra_err_d = 1'b0;
          if (num_rows != '0) state_d = COLLECT;
          else                done_d  = 1'b1;
        end else if (in_valid) begin
          extra_err_d = 1'b1;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (!phase_q) begin
            hi_d    = in_data;
            phase_d = 1'b1;
          end else begin
            // Dropped results still consume a row tag so later tags stay aligned.
            phase_d   = 1'b0;
            row_cnt_d = row_cnt_q + 1'b1;
            if (push_ok) fifo_push  = 1'b1;
            else         overflow_d = 1'b1;
            if (is_last) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_valid) extra_err_d = 1'b1;
        if (fifo_count == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      row_cnt_q   <= '0;
      num_rows_q  <= '0;
      overflow_q  <= 1'b0;
      extra_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      row_cnt_q   <= row_cnt_d;
      num_rows_q  <= num_rows_d;
      overflow_q  <= overflow_d;
      extra_err_q <= extra_err_d;
      done_q      <= done_d;
    end
  end

  smvm_res_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head      = fifo_rdata;
  assign res_valid = !fifo_empty;
  assign res_data  = head.data;
  assign res_row   = head.row;
  assign res_last  = head.last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q || ((state_q == DRAIN) && (fifo_count == '0));
  assign overflow  = overflow_q;
  assign extra_err = extra_err_q;

endmodule

// File: tb/tb_smvm_result_collector.sv
// Self-checking bench for smvm_result_collector: table-driven row vectors
// feeding a scoreboard queue, plus hand-written multi-cycle corner cases.
module tb_smvm_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  num_rows;
   logic        in_valid;
   logic [13:0] in_data;
   logic        res_valid;
   logic        res_ready;
   logic [27:0] res_data;
   logic [7:0]  res_row;
   logic        res_last;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        extra_err;

   typedef struct packed {
      logic [27:0] data;
      logic [7:0]  row;
      logic        last;
   } expEntry_t;

   typedef struct {
      logic [13:0] hi;
      logic [13:0] lo;
      logic [27:0] expData;
   } vector_t;

   expEntry_t expQ[$];
   vector_t   vecTable[6];
   int        checks = 0;
   int        failures = 0;
   expEntry_t gotEntry;
   expEntry_t wantEntry;

   smvm_result_collector dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_rows  (num_rows),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_row   (res_row),
      .res_last  (res_last),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .extra_err (extra_err)
   );

   // 10 ns clock; inputs change 1 ns after the rising edge.
   always #5 clk = ~clk;

   // Compare one observed value against the expected one and tally the outcome.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one SMVM output word (or an idle cycle) for exactly one clock.
   task automatic applyStimulus(input logic v, input logic [13:0] d);
      in_valid = v;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic startJob(input logic [7:0] n);
      start    = 1'b1;
      num_rows = n;
      tick();
      start    = 1'b0;
   endtask

   task automatic sendRow(input logic [13:0] hi, input logic [13:0] lo);
      applyStimulus(1'b1, hi);
      applyStimulus(1'b1, lo);
   endtask

   task automatic expectRow(input logic [27:0] d, input logic [7:0] r, input logic l);
      expEntry_t e;
      e.data = d;
      e.row  = r;
      e.last = l;
      expQ.push_back(e);
   endtask

   // Wait a bounded number of cycles for done; an expired budget counts as a failure.
   task automatic waitDone(input string name, input int budget);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      checkOutput(name, 64'(seen), 64'd1);
   endtask

   // Scoreboard: whatever the DUT hands over on a pop must match the queue head.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         gotEntry.data = res_data;
         gotEntry.row  = res_row;
         gotEntry.last = res_last;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 64'(gotEntry), 64'h1FFFFFFFFF);
         end else begin
            wantEntry = expQ.pop_front();
            checkOutput("scoreboard_entry", 64'(gotEntry), 64'(wantEntry));
         end
      end
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, table-driven job, then the multi-cycle corner cases.
   initial begin
      vecTable[0] = '{14'h0000, 14'h0005, 28'h0000005};
      vecTable[1] = '{14'h3FFF, 14'h3FFB, 28'hFFFFFFB};
      vecTable[2] = '{14'h1FFF, 14'h3FFF, 28'h7FFFFFF};
      vecTable[3] = '{14'h2000, 14'h0000, 28'h8000000};
      vecTable[4] = '{14'h0001, 14'h0002, 28'h0004002};
      vecTable[5] = '{14'h2AAA, 14'h1555, 28'hAAA9555};

      rst = 1'b1; start = 1'b0; num_rows = '0;
      in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
      repeat (3) tick();
      checkOutput("reset_outputs",
                  64'({res_valid, res_data, res_row, res_last, busy, done, overflow, extra_err}), 64'd0);
      rst = 1'b0;
      tick();

      $display("[TB] basic two-row job");
      res_ready = 1'b1;
      startJob(8'd2);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      expectRow(28'h0000005, 8'd0, 1'b0);
      sendRow(14'h0000, 14'h0005);
      expectRow(28'hFFFFFFB, 8'd1, 1'b1);
      sendRow(14'h3FFF, 14'h3FFB);
      checkOutput("t1_done_not_yet", 64'(done), 64'd0);
      tick();
      checkOutput("t1_done_pulse", 64'(done), 64'd1);
      tick();
      checkOutput("t1_done_cleared", 64'(done), 64'd0);
      checkOutput("t1_idle", 64'(busy), 64'd0);
      checkOutput("t1_flags", 64'({overflow, extra_err}), 64'd0);

      $display("[TB] table-driven job");
      startJob(8'd6);
      for (int i = 0; i < 6; i++) begin
         expectRow(vecTable[i].expData, 8'(i), (i == 5));
         sendRow(vecTable[i].hi, vecTable[i].lo);
      end
      waitDone("table_done", 40);
      checkOutput("table_drained", 64'(expQ.size()), 64'd0);

      $display("[TB] overflow job");
      tick();
      res_ready = 1'b0;
      startJob(8'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) expectRow(28'(i + 16'h0100), 8'(i), 1'b0);
         sendRow(14'h0000, 14'(i + 16'h0100));
      end
      checkOutput("t2_overflow", 64'(overflow), 64'd1);
      checkOutput("t2_busy_drain", 64'({busy, res_valid, done}), 64'b110);
      checkOutput("t2_head_row0", 64'({res_row, res_data}), 64'({8'd0, 28'h0000100}));
      res_ready = 1'b1;
      waitDone("t2_done", 40);
      checkOutput("t2_drained", 64'(expQ.size()), 64'd0);
      checkOutput("t2_overflow_sticky", 64'(overflow), 64'd1);
      tick();

      $display("[TB] zero-row job");
      startJob(8'd0);
      checkOutput("t3_done", 64'({done, busy, res_valid}), 64'b100);
      tick();
      checkOutput("t3_after", 64'({done, busy, res_valid}), 64'b000);

      $display("[TB] ignored start and stray word");
      startJob(8'd1);
      startJob(8'd5);
      expectRow(28'h0000007, 8'd0, 1'b1);
      sendRow(14'h0000, 14'h0007);
      waitDone("t4_done", 10);
      tick();
      checkOutput("t4_no_err_yet", 64'(extra_err), 64'd0);
      applyStimulus(1'b1, 14'h1234);
      checkOutput("t4_extra_err", 64'({extra_err, res_valid}), 64'b10);

      $display("[TB] reset mid-job");
      startJob(8'd1);
      applyStimulus(1'b1, 14'h3FFF);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("t5_reset_outputs",
                  64'({res_valid, res_data, res_row, res_last, busy, done, overflow, extra_err}), 64'd0);
      rst = 1'b0;
      tick();
      startJob(8'd1);
      expectRow(28'h0004002, 8'd0, 1'b1);
      sendRow(14'h0001, 14'h0002);
      waitDone("t5_done", 10);
      tick();

      $display("[TB] push into full FIFO with simultaneous pop");
      res_ready = 1'b0;
      startJob(8'd9);
      for (int i = 0; i < 8; i++) begin
         expectRow(28'(i + 16'h0200), 8'(i), 1'b0);
         sendRow(14'h0000, 14'(i + 16'h0200));
      end
      applyStimulus(1'b1, 14'h0000);
      expectRow(28'h0000208, 8'd8, 1'b1);
      in_valid  = 1'b1;
      in_data   = 14'h0208;
      res_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      res_ready = 1'b0;
      checkOutput("t6_no_overflow", 64'(overflow), 64'd0);
      checkOutput("t6_head_row1", 64'({res_valid, res_row}), 64'({1'b1, 8'd1}));
      res_ready = 1'b1;
      waitDone("t6_done", 40);
      checkOutput("t6_drained", 64'(expQ.size()), 64'd0);
      checkOutput("t6_overflow_final", 64'(overflow), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
